// File: rtl/lsu_dmem_master.sv
// ============================================================================
// Module   : lsu_dmem_master
// Brief    : Load/store initiator for a byte-strobed, word-addressed data SRAM.
//            Optional perf counters enabled by defining LSU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_dmem_master #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_fault,
    output logic              data_enable,
    output logic              data_read,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_store,
    input  logic [31:0]       ram_fetch,
    output logic [31:0]       cnt_load,
    output logic [31:0]       cnt_store,
    output logic [31:0]       cnt_fault
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]  state, state_nxt;
    logic        accept;
    logic        illegal, misaligned, out_of_range;
    logic [1:0]  fault_code;
    logic [3:0]  strb;
    logic [31:0] store_data;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic        req_ready_nxt, rsp_valid_nxt, data_enable_nxt, data_read_nxt;

    assign accept = req_valid & req_ready;

    // Request decode; fault priority is illegal > misaligned > range
    always_comb begin
        illegal      = req_we ? (req_funct3 >= 3'd3)
                              : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
        misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        out_of_range = req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2];
        if (illegal)           fault_code = 2'b11;
        else if (misaligned)   fault_code = 2'b01;
        else if (out_of_range) fault_code = 2'b10;
        else                   fault_code = 2'b00;
    end

    always_comb begin
        strb       = 4'b0000;
        store_data = 32'h0;
        case (req_funct3[1:0])
            2'b00: begin
                strb       = 4'b0001 << req_addr[1:0];
                store_data = {24'h0, req_wdata[7:0]};
            end
            2'b01: begin
                strb       = req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {16'h0, req_wdata[15:0]};
            end
            default: begin
                strb       = 4'b1111;
                store_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        sel_byte  = ram_fetch[8*off_q +: 8];
        sel_half  = off_q[1] ? ram_fetch[31:16] : ram_fetch[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'h0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'h0, sel_half};
            default: load_data = ram_fetch;
        endcase
    end

    // State register plus the registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            data_enable <= 1'b0;
            data_read   <= 1'b1;
        end else begin
            state       <= state_nxt;
            req_ready   <= req_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            data_enable <= data_enable_nxt;
            data_read   <= data_read_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (fault_code != 2'b00) ? RESP : ACCESS;
            ACCESS:  state_nxt = we_q ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only IDLE -> ACCESS enters ACCESS, so the live req_we is the right direction
    always_comb begin
        req_ready_nxt   = (state_nxt == IDLE);
        rsp_valid_nxt   = (state_nxt == RESP);
        data_enable_nxt = (state_nxt == ACCESS);
        data_read_nxt   = !((state_nxt == ACCESS) && req_we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            rsp_rdata   <= 32'h0;
            rsp_fault   <= 2'b00;
            mem_wstrb   <= 4'b0000;
            ram_address <= '0;
            ram_store   <= 32'h0;
        end else begin
            if (state == IDLE && accept) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                off_q     <= req_addr[1:0];
                rsp_fault <= fault_code;
                rsp_rdata <= 32'h0;
                if (fault_code == 2'b00) begin
                    ram_address <= req_addr[ADDR_W+1:2];
                    mem_wstrb   <= req_we ? strb : 4'b0000;
                    ram_store   <= req_we ? store_data : 32'h0;
                end
            end else if (state == ACCESS) begin
                mem_wstrb <= 4'b0000;
                ram_store <= 32'h0;
            end else if (state == CAPTURE) begin
                rsp_rdata <= load_data;
            end
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_load  <= 32'h0;
            cnt_store <= 32'h0;
            cnt_fault <= 32'h0;
        end else begin
            if (state == CAPTURE)                          cnt_load  <= cnt_load + 32'd1;
            if (state == ACCESS && we_q)                   cnt_store <= cnt_store + 32'd1;
            if (state == IDLE && accept && fault_code != 2'b00) cnt_fault <= cnt_fault + 32'd1;
        end
    end
`else
    assign cnt_load  = 32'h0;
    assign cnt_store = 32'h0;
    assign cnt_fault = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
// ============================================================================
// Module   : tb_lsu_dmem_master
// Brief    : Directed self-checking bench for lsu_dmem_master with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_dmem_master;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_fault;
    logic              data_enable;
    logic              data_read;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_store;
    logic [31:0]       ram_fetch = 32'h0;
    logic [31:0]       cnt_load, cnt_store, cnt_fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    lsu_dmem_master #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .data_enable(data_enable), .data_read(data_read),
        .mem_wstrb(mem_wstrb), .ram_address(ram_address), .ram_store(ram_store),
        .ram_fetch(ram_fetch), .cnt_load(cnt_load), .cnt_store(cnt_store),
        .cnt_fault(cnt_fault)
    );

    always #5 clk = ~clk;

    // SRAM wrapper model: right-justified store data is routed to the strobed lanes
    always @(posedge clk) begin
        if (data_enable) begin
            if (data_read) begin
                ram_fetch <= mem[ram_address];
            end else begin
                case (mem_wstrb)
                    4'b0001: mem[ram_address][7:0]   <= ram_store[7:0];
                    4'b0010: mem[ram_address][15:8]  <= ram_store[7:0];
                    4'b0100: mem[ram_address][23:16] <= ram_store[7:0];
                    4'b1000: mem[ram_address][31:24] <= ram_store[7:0];
                    4'b0011: mem[ram_address][15:0]  <= ram_store[15:0];
                    4'b1100: mem[ram_address][31:16] <= ram_store[15:0];
                    4'b1111: mem[ram_address]        <= ram_store;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request; records latency, response, and the ACCESS-cycle SRAM outputs
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit release_rsp,
                          output int lat, output logic [31:0] rdata, output logic [1:0] fault,
                          output logic de_seen, output logic [31:0] acc_addr,
                          output logic [3:0] acc_strb, output logic acc_read,
                          output logic [31:0] acc_store);
        de_seen = 1'b0; acc_addr = 32'hX; acc_strb = 4'hX; acc_read = 1'bX; acc_store = 32'hX;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        forever begin
            if (data_enable) begin
                de_seen   = 1'b1;
                acc_addr  = 32'(ram_address);
                acc_strb  = mem_wstrb;
                acc_read  = data_read;
                acc_store = ram_store;
            end
            if (rsp_valid || lat >= 10) break;
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        rdata = rsp_rdata;
        fault = rsp_fault;
        if (release_rsp) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    int          lat;
    logic [31:0] rd, aa, as;
    logic [1:0]  ft;
    logic        de, ar;
    logic [3:0]  ast;

    initial begin
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_data_en",   32'(data_enable), 32'd0);
        check("rst_data_read", 32'(data_read), 32'd1);
        check("rst_wstrb",     32'(mem_wstrb), 32'd0);
        check("rst_ram_store", ram_store, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // SW 0x10
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("sw_addr", aa, 32'd4);
        check("sw_strb", 32'(ast), 32'hF);
        check("sw_read", 32'(ar), 32'd0);
        check("sw_store", as, 32'hDEADBEEF);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_fault", 32'(ft), 32'd0);
        check("sw_rdata", rd, 32'd0);
        check("idle_read", 32'(data_read), 32'd1);
        check("idle_store", ram_store, 32'd0);

        // SB 0x13 then byte loads
        do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("sb_strb", 32'(ast), 32'h8);
        check("sb_store", as, 32'h000000A5);
        check("sb_lat", 32'(lat), 32'd2);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("lb_rdata", rd, 32'hFFFFFFA5);
        check("lb_lat", 32'(lat), 32'd3);
        check("lb_read", 32'(ar), 32'd1);
        check("lb_strb", 32'(ast), 32'h0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("lbu_rdata", rd, 32'h000000A5);
        check("lbu_lat", 32'(lat), 32'd3);

        // Halfword loads
        do_req(1'b1, 3'b010, 32'h20, 32'h80017FFF, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("lh_rdata", rd, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 32'h20, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("lhu_rdata", rd, 32'h00007FFF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("lw_rdata", rd, 32'hA5ADBEEF);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("lbu1_rdata", rd, 32'h000000BE);

        // Faults
        do_req(1'b0, 3'b010, 32'h21, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("mis_fault", 32'(ft), 32'd1);
        check("mis_no_de", 32'(de), 32'd0);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_rdata", rd, 32'd0);
        do_req(1'b1, 3'b010, 32'h0001_0000, 32'h1, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("rng_fault", 32'(ft), 32'd2);
        check("rng_no_de", 32'(de), 32'd0);
        do_req(1'b1, 3'b011, 32'h10, 32'h1, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("ill_fault", 32'(ft), 32'd3);
`ifdef LSU_PERF_CNT_EN
        check("cnt_load", cnt_load, 32'd6);
        check("cnt_store", cnt_store, 32'd3);
        check("cnt_fault", cnt_fault, 32'd3);
`else
        check("cnt_load", cnt_load, 32'd0);
        check("cnt_store", cnt_store, 32'd0);
        check("cnt_fault", cnt_fault, 32'd0);
`endif

        // Priority: illegal over misaligned/range, misaligned over range
        do_req(1'b1, 3'b011, 32'h0001_0001, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("pri_ill", 32'(ft), 32'd3);
        do_req(1'b0, 3'b001, 32'h0001_0001, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("pri_mis", 32'(ft), 32'd1);
        do_req(1'b0, 3'b110, 32'h10, 32'h0, 1'b1, lat, rd, ft, de, aa, ast, ar, as);
        check("ld_ill", 32'(ft), 32'd3);

        // Back-pressure hold with ignored request pulses
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, lat, rd, ft, de, aa, ast, ar, as);
        check("hold_first", rd, 32'h80017FFF);
        for (int i = 0; i < 5; i++) begin
            req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h55;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, 32'h80017FFF);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_no_de", 32'(data_enable), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("hold_drop", 32'(rsp_valid), 32'd0);
        check("hold_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("hold_no_acc", 32'(data_enable), 32'd0);

        // Asynchronous reset during ACCESS
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h1234; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("arst_pre_de", 32'(data_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_de", 32'(data_enable), 32'd0);
        check("arst_rsp", 32'(rsp_valid), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_cnt_load", cnt_load, 32'd0);
        check("arst_cnt_fault", cnt_fault, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("arst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
